// File: rtl/sprite_pkg.sv
// Shared sizes, FSM state encoding and bit helpers for the ghost sprite reader.
package sprite_pkg;

  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 16;
  localparam int COORD_W  = 10;
  localparam int SEL_W    = 3;
  localparam int ROM_AW   = 7;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    FETCH,
    ARMED,
    SHIFT
  } state_t;

  function automatic logic [SPRITE_W-1:0] bit_reverse(input logic [SPRITE_W-1:0] v);
    logic [SPRITE_W-1:0] r;
    for (int i = 0; i < SPRITE_W; i++) begin
      r[i] = v[SPRITE_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ghost_sprite_reader_if.sv
// Video-timing, sprite-placement, ROM and pixel signals of the ghost sprite reader.
interface ghost_sprite_reader_if #(
  parameter int COORD_W = sprite_pkg::COORD_W
);
  logic               frame_start;
  logic               line_start;
  logic               pix_en;
  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic [COORD_W-1:0] GhostX;
  logic [COORD_W-1:0] GhostY;
  logic [2:0]         sprite_sel;
  logic               mirror;
  logic [6:0]         rom_addr;
  logic [15:0]        rom_data;
  logic               pixel_on;
  logic               busy;

  modport slave (
    input  frame_start, line_start, pix_en, DrawX, DrawY,
    input  GhostX, GhostY, sprite_sel, mirror, rom_data,
    output rom_addr, pixel_on, busy
  );

  modport master (
    output frame_start, line_start, pix_en, DrawX, DrawY,
    output GhostX, GhostY, sprite_sel, mirror, rom_data,
    input  rom_addr, pixel_on, busy
  );
endinterface

// File: rtl/sprite_row_shifter.sv
// Serialises one fetched sprite row onto pixel_on, one pixel per pix_en strobe.
module sprite_row_shifter #(
  parameter int SPRITE_W = 16
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                clear,
  input  logic                load,
  input  logic                advance,
  input  logic [SPRITE_W-1:0] row_in,
  output logic                pixel_on,
  output logic                last
);

  localparam int CNT_W = $clog2(SPRITE_W + 1);

  logic [SPRITE_W-1:0] shifter;
  logic [CNT_W-1:0]    cnt;

  assign last = (cnt == CNT_W'(SPRITE_W));

  // Load emits the leftmost pixel at once, so the shifter holds the remaining pixels.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pixel_on <= 1'b0;
      shifter  <= '0;
      cnt      <= '0;
    end else if (clear) begin
      pixel_on <= 1'b0;
      shifter  <= '0;
      cnt      <= '0;
    end else if (load) begin
      pixel_on <= row_in[SPRITE_W-1];
      shifter  <= row_in << 1;
      cnt      <= CNT_W'(1);
    end else if (advance) begin
      if (last) begin
        pixel_on <= 1'b0;
      end else begin
        pixel_on <= shifter[SPRITE_W-1];
        shifter  <= shifter << 1;
        cnt      <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ghost_sprite_reader.sv
// Per-line sprite row fetch: shadows the sprite placement each frame, fetches the
// ROM row that intersects the upcoming line and streams it out at GhostX.
module ghost_sprite_reader
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = sprite_pkg::SPRITE_W,
  parameter int SPRITE_H = sprite_pkg::SPRITE_H,
  parameter int COORD_W  = sprite_pkg::COORD_W
) (
  input logic                  Clk,
  input logic                  Reset_n,
  ghost_sprite_reader_if.slave bus
);

  state_t              state;
  logic [COORD_W-1:0]  shadow_x;
  logic [COORD_W-1:0]  shadow_y;
  logic [2:0]          shadow_sel;
  logic                shadow_mirror;
  logic [SPRITE_W-1:0] row_buf;
  logic [6:0]          addr_q;

  logic signed [COORD_W:0] diff;
  logic                    row_hit;
  logic [6:0]              calc_addr;
  logic                    load;
  logic                    advance;
  logic                    last;

  // The sign bit of the widened difference rejects lines above the sprite.
  always_comb begin
    diff      = $signed({1'b0, bus.DrawY}) - $signed({1'b0, shadow_y});
    row_hit   = !diff[COORD_W] && (diff[COORD_W-1:0] < COORD_W'(SPRITE_H));
    calc_addr = {shadow_sel, diff[3:0]};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow_x      <= '0;
      shadow_y      <= '0;
      shadow_sel    <= '0;
      shadow_mirror <= 1'b0;
    end else if (bus.frame_start) begin
      shadow_x      <= bus.GhostX;
      shadow_y      <= bus.GhostY;
      shadow_sel    <= bus.sprite_sel;
      shadow_mirror <= bus.mirror;
    end
  end

  // line_start restarts the row from any state; a missed line still arms with a blank row.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      row_buf <= '0;
      addr_q  <= '0;
    end else if (bus.line_start) begin
      state <= CALC;
    end else begin
      case (state)
        CALC: begin
          if (row_hit) begin
            addr_q <= calc_addr;
            state  <= FETCH;
          end else begin
            row_buf <= '0;
            state   <= ARMED;
          end
        end
        FETCH: begin
          row_buf <= shadow_mirror ? bit_reverse(bus.rom_data) : bus.rom_data;
          state   <= ARMED;
        end
        ARMED: begin
          if (load) state <= SHIFT;
        end
        SHIFT: begin
          if (advance && last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign load    = (state == ARMED) && bus.pix_en && (bus.DrawX == shadow_x);
  assign advance = (state == SHIFT) && bus.pix_en;

  assign bus.rom_addr = (state == CALC && row_hit) ? calc_addr :
                        (state == FETCH)           ? addr_q    : 7'd0;
  assign bus.busy     = (state != IDLE);

  sprite_row_shifter #(
    .SPRITE_W (SPRITE_W)
  ) u_shifter (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .clear    (bus.line_start),
    .load     (load),
    .advance  (advance),
    .row_in   (row_buf),
    .pixel_on (bus.pixel_on),
    .last     (last)
  );

endmodule

// File: tb/tb_ghost_sprite_reader.sv
// Self-checking bench for ghost_sprite_reader: column-window pixel model plus directed literals.
module tb_ghost_sprite_reader;

  logic Clk = 1'b0;
  logic Reset_n;

  always #5 Clk = ~Clk;

  ghost_sprite_reader_if bus ();

  ghost_sprite_reader dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  logic [15:0] rom [0:127];
  assign bus.rom_data = rom[bus.rom_addr];

  int chk_cnt = 0;
  int err_cnt = 0;

  int          m_sx, m_sy, m_sel;
  logic        m_mir;
  int          lx, off, d, sx_e, sy_e, sel_e;
  logic        lmir, mir_e;
  logic [15:0] lbits;
  logic        m_pix;

  logic        seen [0:1023];
  logic [6:0]  calc_addr;
  logic        calc_busy, calc_pix, fetch_seen;

  task automatic checkOutput(input string name, input int act, input int exp);
    chk_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a line lights columns [x, x+16) from the ROM row selected by the line's offset into the sprite.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_sx = 0; m_sy = 0; m_sel = 0; m_mir = 1'b0;
      lx = 0; lmir = 1'b0; lbits = 16'h0; m_pix = 1'b0;
    end else begin
      if (bus.line_start) begin
        sx_e  = bus.frame_start ? int'(bus.GhostX)     : m_sx;
        sy_e  = bus.frame_start ? int'(bus.GhostY)     : m_sy;
        sel_e = bus.frame_start ? int'(bus.sprite_sel) : m_sel;
        mir_e = bus.frame_start ? bus.mirror           : m_mir;
        d     = int'(bus.DrawY) - sy_e;
        lx    = sx_e;
        lmir  = mir_e;
        lbits = (d >= 0 && d < 16) ? rom[sel_e * 16 + d] : 16'h0;
        m_pix = 1'b0;
      end else if (bus.pix_en) begin
        off = int'(bus.DrawX) - lx;
        if (off >= 0 && off < 16) m_pix = lmir ? lbits[off] : lbits[15 - off];
        else                      m_pix = 1'b0;
      end
      if (bus.frame_start) begin
        m_sx  = int'(bus.GhostX);
        m_sy  = int'(bus.GhostY);
        m_sel = int'(bus.sprite_sel);
        m_mir = bus.mirror;
      end
    end
  end

  always @(negedge Clk) begin
    if (Reset_n === 1'b1) checkOutput("pixel_on_model", int'(bus.pixel_on), int'(m_pix));
  end

  task automatic doFrame(input int gx, input int gy, input int sel, input logic mir);
    bus.GhostX      = 10'(gx);
    bus.GhostY      = 10'(gy);
    bus.sprite_sel  = 3'(sel);
    bus.mirror      = mir;
    bus.frame_start = 1'b1;
    @(posedge Clk); #2;
    bus.frame_start = 1'b0;
  endtask

  // One video line: line_start, three blank cycles, then ncols pixel strobes (optionally gapped).
  task automatic applyStimulus(input int y, input int ncols, input bit gap, input bit with_frame);
    bus.line_start  = 1'b1;
    bus.frame_start = with_frame;
    bus.DrawY       = 10'(y);
    bus.DrawX       = 10'd0;
    bus.pix_en      = 1'b0;
    @(posedge Clk); #2;
    bus.line_start  = 1'b0;
    bus.frame_start = 1'b0;
    calc_addr  = bus.rom_addr;
    calc_busy  = bus.busy;
    calc_pix   = bus.pixel_on;
    fetch_seen = (bus.rom_addr != 7'd0);
    for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
    repeat (3) begin
      @(posedge Clk); #2;
      if (bus.rom_addr != 7'd0) fetch_seen = 1'b1;
    end
    for (int c = 0; c < ncols; c++) begin
      bus.DrawX  = 10'(c);
      bus.pix_en = 1'b1;
      @(posedge Clk); #2;
      seen[c] = bus.pixel_on;
      if (bus.rom_addr != 7'd0) fetch_seen = 1'b1;
      if (gap) begin
        bus.pix_en = 1'b0;
        @(posedge Clk); #2;
      end
    end
    bus.pix_en = 1'b0;
  endtask

  function automatic logic [15:0] window(input int x);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[15 - i] = seen[x + i];
    return p;
  endfunction

  initial begin
    int ones;
    Reset_n         = 1'b0;
    bus.frame_start = 1'b0;
    bus.line_start  = 1'b0;
    bus.pix_en      = 1'b0;
    bus.DrawX       = '0;
    bus.DrawY       = '0;
    bus.GhostX      = '0;
    bus.GhostY      = '0;
    bus.sprite_sel  = '0;
    bus.mirror      = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = 16'((i * 16'h1ABD) ^ 16'h5A5A);
    rom[7'h10] = 16'hF00F;
    rom[7'h12] = 16'hA5C3;
    rom[7'h13] = 16'hFFFF;

    repeat (3) @(posedge Clk);
    #2;
    checkOutput("reset_pixel_on", int'(bus.pixel_on), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_rom_addr", int'(bus.rom_addr), 0);
    Reset_n = 1'b1;
    @(posedge Clk); #2;

    doFrame(100, 50, 1, 1'b0);
    applyStimulus(52, 128, 1'b0, 1'b0);
    checkOutput("hit_rom_addr", int'(calc_addr), 'h12);
    checkOutput("hit_pattern", int'(window(100)), 'hA5C3);
    checkOutput("hit_col116_off", int'(seen[116]), 0);
    checkOutput("hit_col99_off", int'(seen[99]), 0);

    doFrame(100, 50, 1, 1'b1);
    applyStimulus(52, 128, 1'b0, 1'b0);
    checkOutput("mirror_rom_addr", int'(calc_addr), 'h12);
    checkOutput("mirror_pattern", int'(window(100)), 'hC3A5);

    doFrame(100, 50, 1, 1'b0);
    applyStimulus(49, 128, 1'b0, 1'b0);
    checkOutput("miss49_no_fetch", int'(fetch_seen), 0);
    checkOutput("miss49_busy", int'(calc_busy), 1);
    applyStimulus(66, 128, 1'b0, 1'b0);
    checkOutput("miss66_no_fetch", int'(fetch_seen), 0);
    ones = 0;
    for (int i = 0; i < 128; i++) ones += int'(seen[i]);
    checkOutput("miss66_dark", ones, 0);

    applyStimulus(51, 128, 1'b1, 1'b0);
    checkOutput("gap_rom_addr", int'(calc_addr), 'h11);

    applyStimulus(53, 105, 1'b0, 1'b0);
    checkOutput("abort_pre_pixel", int'(seen[104]), 1);
    applyStimulus(53, 128, 1'b0, 1'b0);
    checkOutput("abort_pixel_off", int'(calc_pix), 0);
    checkOutput("abort_busy", int'(calc_busy), 1);
    checkOutput("abort_calc_addr", int'(calc_addr), 'h13);

    bus.GhostX     = 10'd100;
    bus.GhostY     = 10'd52;
    bus.sprite_sel = 3'd1;
    bus.mirror     = 1'b0;
    applyStimulus(52, 128, 1'b0, 1'b1);
    checkOutput("simul_rom_addr", int'(calc_addr), 'h10);
    checkOutput("simul_pattern", int'(window(100)), 'hF00F);

    doFrame(1020, 50, 1, 1'b0);
    applyStimulus(50, 1024, 1'b0, 1'b0);
    checkOutput("clip_last_col", int'(seen[1023]), 1);
    applyStimulus(51, 20, 1'b0, 1'b0);
    ones = 0;
    for (int i = 0; i < 4; i++) ones += int'(seen[i]);
    checkOutput("clip_no_wrap", ones, 0);

    doFrame(100, 50, 1, 1'b0);
    applyStimulus(53, 103, 1'b0, 1'b0);
    checkOutput("async_pre_pixel", int'(bus.pixel_on), 1);
    checkOutput("async_pre_busy", int'(bus.busy), 1);
    Reset_n = 1'b0;
    #1;
    checkOutput("async_pixel_off", int'(bus.pixel_on), 0);
    checkOutput("async_busy_off", int'(bus.busy), 0);
    checkOutput("async_rom_addr", int'(bus.rom_addr), 0);
    @(posedge Clk); #2;
    Reset_n = 1'b1;
    @(posedge Clk); #2;
    checkOutput("post_reset_busy", int'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
